// File: rtl/picodevice_mem_arbiter.sv
// Round-robin arbiter sharing one native memory port between two masters.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module picodevice_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      r_state;
  state_t      w_next_state;
  logic        r_s_valid;
  logic        r_s_instr;
  logic [31:0] r_s_addr;
  logic [31:0] r_s_wdata;
  logic [3:0]  r_s_wstrb;
  logic [1:0]  r_grant;
  logic        r_last_m1;
  logic        r_m0_ready;
  logic        r_m1_ready;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        r_timeout_err;

  logic        w_pick_m1;
  logic        w_start;
  logic        w_done;
  logic        w_abort;
  logic        w_finish;

  // On a tie the master that was not served last wins.
  assign w_pick_m1 = m1_mem_valid & (~m0_mem_valid | ~r_last_m1);
  assign w_start   = (r_state == ST_IDLE) & (m0_mem_valid | m1_mem_valid);
  assign w_done    = (r_state == ST_BUSY) & s_mem_ready;
  assign w_finish  = w_done | w_abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wdog_cnt;

  // A same-edge s_mem_ready takes priority over expiry.
  assign w_abort = (r_state == ST_BUSY) & ~s_mem_ready & (r_wdog_cnt == LP_WDOG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_cnt <= 16'd0;
    end else if (w_start) begin
      r_wdog_cnt <= 16'd0;
    end else if ((r_state == ST_BUSY) && !s_mem_ready) begin
      r_wdog_cnt <= r_wdog_cnt + 16'd1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start)  w_next_state = ST_BUSY;
      ST_BUSY: if (w_finish) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_valid     <= 1'b0;
      r_s_instr     <= 1'b0;
      r_s_addr      <= 32'd0;
      r_s_wdata     <= 32'd0;
      r_s_wstrb     <= 4'd0;
      r_grant       <= 2'b00;
      r_last_m1     <= 1'b1;
      r_m0_ready    <= 1'b0;
      r_m1_ready    <= 1'b0;
      r_m0_rdata    <= 32'd0;
      r_m1_rdata    <= 32'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_m0_ready    <= 1'b0;
      r_m1_ready    <= 1'b0;
      r_timeout_err <= 1'b0;
      if (w_start) begin
        r_s_valid <= 1'b1;
        r_s_instr <= w_pick_m1 ? m1_mem_instr : m0_mem_instr;
        r_s_addr  <= w_pick_m1 ? m1_mem_addr  : m0_mem_addr;
        r_s_wdata <= w_pick_m1 ? m1_mem_wdata : m0_mem_wdata;
        r_s_wstrb <= w_pick_m1 ? m1_mem_wstrb : m0_mem_wstrb;
        r_grant   <= w_pick_m1 ? 2'b10 : 2'b01;
      end
      if (w_finish) begin
        r_s_valid     <= 1'b0;
        r_grant       <= 2'b00;
        r_last_m1     <= r_grant[1];
        r_m0_ready    <= r_grant[0];
        r_m1_ready    <= r_grant[1];
        r_timeout_err <= w_abort;
        if (r_grant[0]) r_m0_rdata <= w_done ? s_mem_rdata : TIMEOUT_RDATA;
        if (r_grant[1]) r_m1_rdata <= w_done ? s_mem_rdata : TIMEOUT_RDATA;
      end
    end
  end

  assign s_mem_valid  = r_s_valid;
  assign s_mem_instr  = r_s_instr;
  assign s_mem_addr   = r_s_addr;
  assign s_mem_wdata  = r_s_wdata;
  assign s_mem_wstrb  = r_s_wstrb;
  assign grant        = r_grant;
  assign m0_mem_ready = r_m0_ready;
  assign m1_mem_ready = r_m1_ready;
  assign m0_mem_rdata = r_m0_rdata;
  assign m1_mem_rdata = r_m1_rdata;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_picodevice_mem_arbiter.sv
// Self-checking bench for picodevice_mem_arbiter using a transaction-level model.
// Watchdog checks follow MEM_ARB_TIMEOUT_EN when it is defined.
module tb_picodevice_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_mem_valid, m0_mem_instr, m1_mem_valid, m1_mem_instr;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m1_mem_addr, m1_mem_wdata;
  logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
  logic        m0_mem_ready, m1_mem_ready;
  logic [31:0] m0_mem_rdata, m1_mem_rdata;
  logic        s_mem_valid, s_mem_instr, s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state: pending requests, request fields, last served master, held rdata.
  bit          p[2];
  logic        f_instr[2];
  logic [31:0] f_addr[2];
  logic [31:0] f_wdata[2];
  logic [3:0]  f_wstrb[2];
  int          last_m;
  logic [31:0] exp_rd[2];
  logic [1:0]  obs_grant;

  picodevice_mem_arbiter #(.TIMEOUT_CYCLES(4), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready),
    .s_mem_rdata(s_mem_rdata), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int i);
    if (i == 0) begin
      m0_mem_valid = p[0]; m0_mem_instr = f_instr[0]; m0_mem_addr = f_addr[0];
      m0_mem_wdata = f_wdata[0]; m0_mem_wstrb = f_wstrb[0];
    end else begin
      m1_mem_valid = p[1]; m1_mem_instr = f_instr[1]; m1_mem_addr = f_addr[1];
      m1_mem_wdata = f_wdata[1]; m1_mem_wstrb = f_wstrb[1];
    end
  endtask

  task automatic new_req(input int i, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    p[i] = 1'b1; f_instr[i] = ins; f_addr[i] = a; f_wdata[i] = wd; f_wstrb[i] = ws;
    drive(i);
  endtask

  task automatic rand_req(input int i);
    new_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic release_m(input int i);
    p[i] = 1'b0;
    drive(i);
  endtask

  task automatic model_reset();
    last_m = 1; exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    release_m(0); release_m(1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_valid"}, {31'd0, s_mem_valid}, 32'd0);
    check({tag, "_grant"}, {30'd0, grant}, 32'd0);
    check({tag, "_s_addr"}, s_mem_addr, 32'd0);
    check({tag, "_s_wdata"}, s_mem_wdata, 32'd0);
    check({tag, "_s_instr_wstrb"}, {27'd0, s_mem_instr, s_mem_wstrb}, 32'd0);
    check({tag, "_readies"}, {30'd0, m1_mem_ready, m0_mem_ready}, 32'd0);
    check({tag, "_m0_rdata"}, m0_mem_rdata, 32'd0);
    check({tag, "_m1_rdata"}, m1_mem_rdata, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  // Asynchronous reset applied away from the clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_reset("reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_no_ready", {30'd0, m1_mem_ready, m0_mem_ready}, 32'd0);
    reset = 1'b0;
  endtask

  // One complete transaction; called from an IDLE-cycle negedge, returns at the next IDLE negedge.
  task automatic serve(input int wait_n, input bit drop_mid, input bit rereq, input bit jitter,
                       input logic [31:0] rd, output int win, output int rcyc);
    int          o;
    logic        e_instr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    if (p[0] && p[1]) win = (last_m == 0) ? 1 : 0;
    else              win = p[0] ? 0 : 1;
    o = 1 - win;
    e_instr = f_instr[win]; e_addr = f_addr[win]; e_wdata = f_wdata[win]; e_wstrb = f_wstrb[win];
    @(negedge clk);
    obs_grant = grant;
    check("busy_s_valid", {31'd0, s_mem_valid}, 32'd1);
    check("busy_grant", {30'd0, grant}, (win == 0) ? 32'd1 : 32'd2);
    check("busy_s_addr", s_mem_addr, e_addr);
    check("busy_s_wdata", s_mem_wdata, e_wdata);
    check("busy_s_instr_wstrb", {27'd0, s_mem_instr, s_mem_wstrb}, {27'd0, e_instr, e_wstrb});
    if (drop_mid) release_m(win);
    for (int k = 0; k < wait_n; k++) begin
      if (jitter) rand_req(o);
      @(negedge clk);
      check("hold_s_valid", {31'd0, s_mem_valid}, 32'd1);
      check("hold_fields", s_mem_addr ^ s_mem_wdata ^ {27'd0, s_mem_instr, s_mem_wstrb},
            e_addr ^ e_wdata ^ {27'd0, e_instr, e_wstrb});
      check("hold_readies", {30'd0, m1_mem_ready, m0_mem_ready}, 32'd0);
    end
    s_mem_rdata = rd;
    s_mem_ready = 1'b1;
    @(negedge clk);
    s_mem_ready = 1'b0;
    s_mem_rdata = $urandom;
    rcyc = cyc;
    check("resp_readies", {30'd0, m1_mem_ready, m0_mem_ready}, (win == 0) ? 32'd1 : 32'd2);
    check("resp_rdata_win", (win == 0) ? m0_mem_rdata : m1_mem_rdata, rd);
    check("resp_rdata_other", (o == 0) ? m0_mem_rdata : m1_mem_rdata, exp_rd[o]);
    check("resp_s_valid", {31'd0, s_mem_valid}, 32'd0);
    check("resp_timeout_err", {31'd0, timeout_err}, 32'd0);
    exp_rd[win] = rd;
    last_m = win;
    if (rereq) rand_req(win);
    else       release_m(win);
    @(negedge clk);
    check("idle_readies", {30'd0, m1_mem_ready, m0_mem_ready}, 32'd0);
    check("idle_rdata_hold", m0_mem_rdata ^ m1_mem_rdata, exp_rd[0] ^ exp_rd[1]);
  endtask

  initial begin
    int w, w2, rc0, rc1, n0, n1, vcnt;
    p[0] = 1'b0; p[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f_instr[i] = 1'b0; f_addr[i] = 32'd0; f_wdata[i] = 32'd0; f_wstrb[i] = 4'd0;
    end
    drive(0); drive(1);
    s_mem_ready = 1'b0; s_mem_rdata = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("init");
    reset = 1'b0;

    // Single read with two wait cycles.
    new_req(0, 1'b0, 32'h100, 32'd0, 4'd0);
    serve(2, 0, 0, 0, 32'hCAFE0001, w, rc0);

    // s_mem_ready outside BUSY is ignored.
    s_mem_ready = 1'b1; s_mem_rdata = 32'h5555AAAA;
    repeat (3) begin
      @(negedge clk);
      check("stray_ready", {29'd0, s_mem_valid, m1_mem_ready, m0_mem_ready}, 32'd0);
    end
    s_mem_ready = 1'b0;

    // Tie after reset: m0 first, m1 three cycles later.
    do_reset();
    rand_req(0); rand_req(1);
    serve(0, 0, 0, 0, $urandom, w, rc0);
    check("tie_first_grant", {30'd0, obs_grant}, 32'd1);
    serve(0, 0, 0, 0, $urandom, w2, rc1);
    check("tie_second_grant", {30'd0, obs_grant}, 32'd2);
    check("tie_ready_spacing", rc1 - rc0, 32'd3);

    // Fairness with both masters always requesting.
    n0 = 0; n1 = 0;
    rand_req(0); rand_req(1);
    for (int t = 0; t < 8; t++) begin
      serve($urandom_range(0, 2), 0, 1, 0, $urandom, w, rc0);
      if (obs_grant == 2'b01) n0++;
      if (obs_grant == 2'b10) n1++;
    end
    check("fair_m0_count", n0, 32'd4);
    check("fair_m1_count", n1, 32'd4);
    release_m(0); release_m(1);
    @(negedge clk);

    // Write from m1 held stable while m0 churns its request.
    new_req(1, 1'b0, $urandom, 32'h12345678, 4'b0011);
    serve(5, 0, 0, 1, $urandom, w, rc0);
    check("wr_hold_grant", {30'd0, obs_grant}, 32'd2);
    serve($urandom_range(0, 3), 0, 0, 0, $urandom, w, rc0);
    check("wr_hold_pending_m0", {30'd0, obs_grant}, 32'd1);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      bit dm;
      for (int i = 0; i < 2; i++) if (!p[i] && ($urandom_range(0, 1) == 1)) rand_req(i);
      if (!p[0] && !p[1]) rand_req($urandom_range(0, 1));
      dm = ($urandom_range(0, 4) == 0);
      serve($urandom_range(0, 3), dm, !dm && ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), $urandom, w, rc0);
    end
    while (p[0] || p[1]) serve($urandom_range(0, 2), 0, 0, 0, $urandom, w, rc0);

    // Reset while BUSY abandons the transaction.
    rand_req(0);
    @(negedge clk);
    check("rst_busy_s_valid", {31'd0, s_mem_valid}, 32'd1);
    do_reset();
    rand_req(0); rand_req(1);
    serve(1, 0, 0, 0, $urandom, w, rc0);
    check("rst_then_tie", {30'd0, obs_grant}, 32'd1);
    serve(0, 0, 0, 0, $urandom, w, rc0);

    // Downstream that never completes.
    rand_req(0);
    vcnt = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!s_mem_valid) break;
      vcnt++;
    end
    check("wdog_busy_cycles", vcnt, 32'd4);
    check("wdog_ready", {30'd0, m1_mem_ready, m0_mem_ready}, 32'd1);
    check("wdog_rdata", m0_mem_rdata, 32'hDEADBEEF);
    check("wdog_err_pulse", {31'd0, timeout_err}, 32'd1);
    release_m(0);
    @(negedge clk);
    check("wdog_err_clear", {30'd0, timeout_err, m0_mem_ready}, 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_mem_valid) vcnt++;
      if (timeout_err) vcnt = vcnt + 100;
    end
    check("nowdog_stuck_busy", vcnt, 32'd20);
    check("nowdog_no_ready", {30'd0, m1_mem_ready, m0_mem_ready}, 32'd0);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/picodevice_mem_arbiter.md
# picodevice_mem_arbiter

Two-requester arbiter that shares one picorv32-style native memory port (feeding the AXI4-lite adapter) between two masters, e.g. the core and a DMA/debug engine. Round-robin grant, one outstanding transaction, registered request and response paths. An optional watchdog terminates transactions the downstream never completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles `s_mem_valid` may stay high without `s_mem_ready` before abort (only with `MEM_ARB_TIMEOUT_EN`); legal range 1..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned on abort.

Ports (reset is asynchronous, active-high):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous active-high reset
- m0_mem_valid / m1_mem_valid  in  1  request from master 0/1
- m0_mem_instr / m1_mem_instr  in  1  instruction-fetch flag
- m0_mem_addr / m1_mem_addr  in  32  byte address
- m0_mem_wdata / m1_mem_wdata  in  32  write data
- m0_mem_wstrb / m1_mem_wstrb  in  4  write strobes, 0 = read
- m0_mem_ready / m1_mem_ready  out  1  one-cycle completion pulse
- m0_mem_rdata / m1_mem_rdata  out  32  read data, valid with ready
- s_mem_valid  out  1  request to shared port
- s_mem_instr  out  1  forwarded instr flag
- s_mem_addr  out  32  forwarded address
- s_mem_wdata  out  32  forwarded write data
- s_mem_wstrb  out  4  forwarded strobes
- s_mem_ready  in  1  shared-port completion
- s_mem_rdata  in  32  shared-port read data
- grant  out  2  one-hot owner, 2'b00 when idle
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any `mX_mem_valid`, select winner, latch its instr/addr/wdata/wstrb into `s_mem_*` registers, set `grant`, go BUSY. Else stay.
- Arbitration: one requester -> it wins. Both -> the one not granted last (`last_grant`). After reset `last_grant` = m1, so m0 wins the first tie.
- BUSY: `s_mem_valid`=1, all `s_mem_*` held stable. On `s_mem_ready`=1: latch `s_mem_rdata`, clear `s_mem_valid`, update `last_grant`, go RESP.
- RESP: granted `mX_mem_ready`=1 for exactly one cycle with latched rdata; non-granted ready stays 0; `grant` cleared; go IDLE.
- `s_mem_ready` outside BUSY is ignored.
- Master dropping valid mid-transaction is a protocol violation; the arbiter still completes the transaction and issues the ready pulse.
- `mX_mem_rdata` holds its last value when not ready; rdata is returned for writes as well (don't-care).

## Timing
- Reset (async assert, sync-safe release): state IDLE, all `s_mem_*`=0, `mX_mem_ready`=0, `mX_mem_rdata`=0, `grant`=0, `timeout_err`=0, `last_grant`=m1, watchdog counter 0. Reset mid-transaction abandons it without a ready pulse.
- Valid sampled in IDLE at edge N -> `s_mem_valid` high from cycle N+1.
- `s_mem_ready` sampled at edge M -> `mX_mem_ready` high in cycle M+1 -> IDLE in cycle M+2.
- Minimum request-to-ready latency 3 cycles with zero-wait downstream; throughput one transaction per 3 cycles minimum.
- Requests arriving during BUSY/RESP wait; a pending master is served in the next IDLE cycle.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined: 16-bit counter clears on entry to BUSY and increments each BUSY cycle without `s_mem_ready`. When count reaches TIMEOUT_CYCLES: clear `s_mem_valid`, load TIMEOUT_RDATA, go RESP; `timeout_err` pulses in the RESP cycle together with `mX_mem_ready`. `s_mem_ready` on the same edge as expiry wins (normal completion, no error).
- Not defined: no counter; `timeout_err` tied 0; BUSY waits indefinitely.

## Test plan
- Single read: m0 reads addr 32'h100, downstream ready after 2 wait cycles with rdata 32'hCAFE0001 -> `s_mem_addr`=32'h100, `m0_mem_ready` one cycle with 32'hCAFE0001, `grant`=2'b01 during BUSY.
- Tie after reset: m0 and m1 assert together, zero-wait downstream -> m0 served first, m1 second, `m1_mem_ready` 3 cycles after `m0_mem_ready`.
- Fairness: both masters continuously requesting for 8 transactions -> grants alternate m0, m1, m0, …, exactly 4 each.
- Write hold: m1 writes wdata 32'h12345678, wstrb 4'b0011, ready delayed 5 cycles while m0 changes its inputs -> `s_mem_*` stable throughout, `m0_mem_ready` never asserted.
- Reset mid-BUSY: assert reset while `s_mem_valid`=1 -> all outputs 0 immediately, no ready pulse; after release m0 wins the next tie.
- With `MEM_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=4, downstream never ready -> `s_mem_valid` drops after 4 BUSY cycles, `m0_mem_ready`=1, rdata 32'hDEADBEEF, `timeout_err` pulse; without macro, `s_mem_valid` stays high.
